// File: rtl/and3_bist_pkg.sv
// ---------------------------------------------------------------------------
// and3_bist_pkg
// Shared definitions for the AND3 built-in self-test sequencer:
//   - state_t   : sequencer states {IDLE, WAIT, DONE}
//   - NPAT      : number of exhaustive input patterns (8)
//   - IDX_W     : width of the pattern index (3)
//   - and3_exp(): golden AND3 response for a pattern index
// Optional feature macro used by the design: AND3_BIST_NQ_CHECK_EN
// ---------------------------------------------------------------------------
package and3_bist_pkg;

    localparam int NPAT  = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Expected cell output: index bit k drives input ik, so the AND3 result
    // is simply the reduction-AND of the index.
    function automatic logic and3_exp(input logic [IDX_W-1:0] idx);
        return &idx;
    endfunction

endpackage

// File: rtl/and3_bist_ref.sv
// ---------------------------------------------------------------------------
// and3_bist_ref
// Purely combinational golden-model comparator for the AND3 cell.
// Compares the observed cell output(s) with the truth table for the
// current pattern index.
//
// Ports:
//   idx          in  IDX_W  pattern index currently applied to the cell
//   q            in  1      cell output
//   nq           in  1      complementary cell output (only with
//                           AND3_BIST_NQ_CHECK_EN defined)
//   mismatch     out 1      at least one observed output is wrong
//   mismatch_cnt out 2      number of wrong outputs (0..2)
//
// Macro: AND3_BIST_NQ_CHECK_EN adds the nq port and its comparison.
// ---------------------------------------------------------------------------
module and3_bist_ref
    import and3_bist_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             q,
`ifdef AND3_BIST_NQ_CHECK_EN
    input  logic             nq,
`endif
    output logic             mismatch,
    output logic [1:0]       mismatch_cnt
);

    logic w_exp;
    logic w_q_bad;
    logic w_nq_bad;

    assign w_exp   = and3_exp(idx);
    assign w_q_bad = (q != w_exp);

`ifdef AND3_BIST_NQ_CHECK_EN
    assign w_nq_bad = (nq != ~w_exp);
`else
    assign w_nq_bad = 1'b0;
`endif

    assign mismatch     = w_q_bad | w_nq_bad;
    assign mismatch_cnt = {1'b0, w_q_bad} + {1'b0, w_nq_bad};

endmodule

// File: rtl/and3_bist.sv
// ---------------------------------------------------------------------------
// and3_bist
// Built-in self-test sequencer for a 3-input AND cell. Applies all 8 input
// patterns in order, waits SETTLE cycles per pattern, samples the cell
// output in the last cycle of each pattern and accumulates mismatches.
//
// Parameters:
//   SETTLE  wait cycles per pattern before sampling (0..255)
//   ERRW    width of the saturating mismatch counter
//
// Ports:
//   clk       in  1     clock, rising edge
//   rst       in  1     synchronous active-high reset
//   start     in  1     run request, only honoured in IDLE
//   busy      out 1     patterns being applied
//   done      out 1     one-cycle end-of-run pulse
//   pass      out 1     last completed run had no mismatches
//   err_cnt   out ERRW  mismatch count of last run (saturating)
//   fail_vec  out 8     bit k set when pattern k mismatched
//   i0/i1/i2  out 1     drive the cell under test
//   q         in  1     cell output
//   nq        in  1     complementary cell output (AND3_BIST_NQ_CHECK_EN)
//
// Macro: AND3_BIST_NQ_CHECK_EN enables the nq port and its check; each
// wrong output then counts separately in err_cnt.
// ---------------------------------------------------------------------------
module and3_bist
    import and3_bist_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int ERRW   = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERRW-1:0]  err_cnt,
    output logic [NPAT-1:0]  fail_vec,
    output logic             i0,
    output logic             i1,
    output logic             i2,
    input  logic             q
`ifdef AND3_BIST_NQ_CHECK_EN
    ,
    input  logic             nq
`endif
);

    localparam logic [7:0] SETTLE_W  = 8'(SETTLE);
    localparam int         ERR_SUM_W = ERRW + 1;

    // -----------------------------------------------------------------------
    // State and result registers
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [7:0]         r_wcnt;
    logic [ERRW-1:0]    r_err_cnt;
    logic [NPAT-1:0]    r_fail_vec;
    logic               r_pass;

    state_t             w_state_next;
    logic [IDX_W-1:0]   w_idx_next;
    logic [7:0]         w_wcnt_next;
    logic [ERRW-1:0]    w_err_next;
    logic [NPAT-1:0]    w_fail_next;
    logic               w_pass_next;

    // -----------------------------------------------------------------------
    // Golden-model comparison
    // -----------------------------------------------------------------------
    logic               w_mismatch;
    logic [1:0]         w_mm_cnt;
    logic               w_sample;
    logic [NPAT-1:0]    w_hit_vec;
    logic [ERR_SUM_W-1:0] w_err_sum;
    logic [ERRW-1:0]    w_err_sat;

    and3_bist_ref u_ref (
        .idx          (r_idx),
        .q            (q),
`ifdef AND3_BIST_NQ_CHECK_EN
        .nq           (nq),
`endif
        .mismatch     (w_mismatch),
        .mismatch_cnt (w_mm_cnt)
    );

    // The cell output is only meaningful in the last cycle of a pattern.
    assign w_sample = (r_state == WAIT) && (r_wcnt == 8'd0);

    // One-hot failure contribution of the pattern currently being sampled.
    generate
        for (genvar gi = 0; gi < NPAT; gi++) begin : g_hit
            assign w_hit_vec[gi] = w_mismatch && (r_idx == IDX_W'(gi));
        end
    endgenerate

    // Saturating accumulation: the extra sum bit flags overflow, in which
    // case the counter pins at all-ones.
    assign w_err_sum = {1'b0, r_err_cnt} + ERR_SUM_W'(w_mm_cnt);
    assign w_err_sat = w_err_sum[ERRW] ? {ERRW{1'b1}} : w_err_sum[ERRW-1:0];

    // -----------------------------------------------------------------------
    // Sequencer FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wcnt     <= '0;
            r_err_cnt  <= '0;
            r_fail_vec <= '0;
            r_pass     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_idx      <= w_idx_next;
            r_wcnt     <= w_wcnt_next;
            r_err_cnt  <= w_err_next;
            r_fail_vec <= w_fail_next;
            r_pass     <= w_pass_next;
        end
    end

    // -----------------------------------------------------------------------
    // Sequencer FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_wcnt_next  = r_wcnt;
        w_err_next   = r_err_cnt;
        w_fail_next  = r_fail_vec;
        w_pass_next  = r_pass;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = WAIT;
                    w_idx_next   = '0;
                    w_wcnt_next  = SETTLE_W;
                    w_err_next   = '0;
                    w_fail_next  = '0;
                    w_pass_next  = 1'b0;
                end
            end

            WAIT: begin
                if (r_wcnt != 8'd0) begin
                    w_wcnt_next = r_wcnt - 8'd1;
                end else begin
                    w_err_next  = w_err_sat;
                    w_fail_next = r_fail_vec | w_hit_vec;
                    if (r_idx == IDX_W'(NPAT - 1)) begin
                        w_state_next = DONE;
                        // Registered now so it is already valid while done
                        // is high; includes the final pattern's result.
                        w_pass_next  = (w_err_sat == '0);
                    end else begin
                        w_idx_next  = r_idx + IDX_W'(1);
                        w_wcnt_next = SETTLE_W;
                    end
                end
            end

            DONE: begin
                w_state_next = IDLE;
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign busy     = (r_state == WAIT);
    assign done     = (r_state == DONE);
    assign pass     = r_pass;
    assign err_cnt  = r_err_cnt;
    assign fail_vec = r_fail_vec;

    // Cell inputs follow the pattern index only while testing; otherwise 0.
    assign i0 = busy & r_idx[0];
    assign i1 = busy & r_idx[1];
    assign i2 = busy & r_idx[2];

endmodule

// File: tb/tb_and3_bist.sv
// ---------------------------------------------------------------------------
// tb_and3_bist
// Self-checking bench for and3_bist. Three instances:
//   u_dut   SETTLE=2, main instance with a selectable cell fault model
//   u_dut0  SETTLE=0, q stuck at 1, used for latency and held-start restart
//   u_sat   SETTLE=2, ERRW=2, q stuck at 1, counter saturation
// Expected run results for u_dut go into a scoreboard queue when start is
// driven and are popped by a monitor when done pulses.
// Macro: AND3_BIST_NQ_CHECK_EN (nq connected and exercised when defined).
// ---------------------------------------------------------------------------
module tb_and3_bist;
    import and3_bist_pkg::*;

`ifdef AND3_BIST_NQ_CHECK_EN
    localparam int MAIN_ERRW = 5;
`else
    localparam int MAIN_ERRW = 4;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- main DUT ----------------
    logic                 start = 1'b0;
    logic                 busy, done, pass, i0, i1, i2;
    logic [MAIN_ERRW-1:0] err_cnt;
    logic [7:0]           fail_vec;
    int                   q_mode  = 0;   // 0 correct, 1 stuck-0, 2 stuck-1
    int                   nq_mode = 0;   // 0 inverse of correct cell, 1 stuck-0
    logic                 cell_q, cell_nq;

    assign cell_q  = (q_mode == 0) ? (i0 & i1 & i2) : (q_mode == 2);
    assign cell_nq = (nq_mode == 0) ? ~(i0 & i1 & i2) : 1'b0;

    and3_bist #(.SETTLE(2), .ERRW(MAIN_ERRW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec),
        .i0(i0), .i1(i1), .i2(i2), .q(cell_q)
`ifdef AND3_BIST_NQ_CHECK_EN
        , .nq(cell_nq)
`endif
    );

    // ---------------- SETTLE=0 DUT, q stuck at 1 ----------------
    logic       s0_start = 1'b0;
    logic       s0_busy, s0_done, s0_pass, s0_i0, s0_i1, s0_i2;
    logic [3:0] s0_err;
    logic [7:0] s0_fvec;

    and3_bist #(.SETTLE(0), .ERRW(4)) u_dut0 (
        .clk(clk), .rst(rst), .start(s0_start), .busy(s0_busy), .done(s0_done),
        .pass(s0_pass), .err_cnt(s0_err), .fail_vec(s0_fvec),
        .i0(s0_i0), .i1(s0_i1), .i2(s0_i2), .q(1'b1)
`ifdef AND3_BIST_NQ_CHECK_EN
        , .nq(~(s0_i0 & s0_i1 & s0_i2))
`endif
    );

    // ---------------- ERRW=2 DUT, q stuck at 1 ----------------
    logic       s1_start = 1'b0;
    logic       s1_busy, s1_done, s1_pass, s1_i0, s1_i1, s1_i2;
    logic [1:0] s1_err;
    logic [7:0] s1_fvec;

    and3_bist #(.SETTLE(2), .ERRW(2)) u_sat (
        .clk(clk), .rst(rst), .start(s1_start), .busy(s1_busy), .done(s1_done),
        .pass(s1_pass), .err_cnt(s1_err), .fail_vec(s1_fvec),
        .i0(s1_i0), .i1(s1_i1), .i2(s1_i2), .q(1'b1)
`ifdef AND3_BIST_NQ_CHECK_EN
        , .nq(~(s1_i0 & s1_i1 & s1_i2))
`endif
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        int         lat;
        logic       pass;
        int         err;
        logic [7:0] fvec;
    } exp_t;

    exp_t sb_q[$];
    int   t_start = 0;

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("done_latency", 32'(cyc - t_start), 32'(e.lat));
                check("busy_at_done", 32'(busy), 32'd0);
                check("pass", 32'(pass), 32'(e.pass));
                check("err_cnt", 32'(err_cnt), 32'(e.err));
                check("fail_vec", 32'(fail_vec), 32'(e.fvec));
                $display("run done: lat=%0d pass=%0b err_cnt=%0d fail_vec=%02h",
                         cyc - t_start, pass, err_cnt, fail_vec);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on the main DUT, optionally re-pulse it mid-run, then wait
    // (bounded) for done.
    task automatic run_main(input bit repulse);
        bit seen;
        next_cycle();
        start   = 1'b1;
        t_start = cyc;
        next_cycle();
        start = 1'b0;
        if (repulse) begin
            repeat (4) next_cycle();
            start = 1'b1;
            next_cycle();
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Watchdog in case something blocks outside the bounded loops.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   d0_lat[2];
        int   n_done;
        int   lat1;
        bit   seen;

        // ---------------- reset state ----------------
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
        check("rst_err", 32'(err_cnt), 32'd0);
        check("rst_fvec", 32'(fail_vec), 32'd0);
        check("rst_i", 32'({i2, i1, i0}), 32'd0);
        next_cycle();
        rst = 1'b0;

        // ---------------- correct cell, extra start mid-run ignored -------
        q_mode = 0; nq_mode = 0;
        sb_q.push_back('{lat: 25, pass: 1'b1, err: 0, fvec: 8'h00});
        run_main(1'b1);
        check("pass_held", 32'(pass), 32'd1);
        check("idle_i", 32'({i2, i1, i0}), 32'd0);

        // ---------------- q stuck at 0 ----------------
        q_mode = 1;
        sb_q.push_back('{lat: 25, pass: 1'b0, err: 1, fvec: 8'h80});
        run_main(1'b0);

`ifdef AND3_BIST_NQ_CHECK_EN
        // ---------------- nq stuck at 0, q correct ----------------
        q_mode = 0; nq_mode = 1;
        sb_q.push_back('{lat: 25, pass: 1'b0, err: 7, fvec: 8'h7F});
        run_main(1'b0);
        nq_mode = 0;
`endif

        // ---------------- reset during pattern 3 ----------------
        q_mode = 2;
        next_cycle();
        start = 1'b1;
        t_start = cyc;
        next_cycle();
        start = 1'b0;
        while (cyc < t_start + 5) next_cycle();
        start = 1'b1;                      // ignored: already busy
        next_cycle();
        start = 1'b0;
        while (cyc < t_start + 11) next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check("abort_pattern", 32'({i2, i1, i0}), 32'd3);
        check("abort_err_pre", 32'(err_cnt), 32'd3);
        check("abort_fvec_pre", 32'(fail_vec), 32'h07);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_i", 32'({i2, i1, i0}), 32'd0);
        check("post_rst_err", 32'(err_cnt), 32'd0);
        check("post_rst_fvec", 32'(fail_vec), 32'd0);
        check("post_rst_pass", 32'(pass), 32'd0);
        $display("reset mid-run: busy=%0b err_cnt=%0d", busy, err_cnt);

        // fresh run after the abort
        q_mode = 0;
        sb_q.push_back('{lat: 25, pass: 1'b1, err: 0, fvec: 8'h00});
        run_main(1'b0);

        // ---------------- SETTLE=0, start held: restart after DONE -------
        d0_lat[0] = 0;
        d0_lat[1] = 0;
        n_done    = 0;
        next_cycle();
        s0_start = 1'b1;
        lat1     = cyc;
        for (int k = 0; k < 80 && n_done < 2; k++) begin
            @(negedge clk);
            if (s0_done) begin
                d0_lat[n_done] = cyc - lat1;
                n_done++;
            end
        end
        next_cycle();
        s0_start = 1'b0;
        check("s0_done1_lat", 32'(d0_lat[0]), 32'd9);
        check("s0_done2_lat", 32'(d0_lat[1]), 32'd19);
        check("s0_err", 32'(s0_err), 32'd7);
        check("s0_fvec", 32'(s0_fvec), 32'h7F);
        check("s0_pass", 32'(s0_pass), 32'd0);
        $display("settle0 run: lat=%0d,%0d err_cnt=%0d fail_vec=%02h",
                 d0_lat[0], d0_lat[1], s0_err, s0_fvec);

        // ---------------- ERRW=2 saturation ----------------
        next_cycle();
        s1_start = 1'b1;
        lat1     = cyc;
        next_cycle();
        s1_start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (s1_done) seen = 1'b1;
        end
        check("sat_done_lat", 32'(seen ? cyc - lat1 : -1), 32'd25);
        check("sat_err", 32'(s1_err), 32'd3);
        check("sat_fvec", 32'(s1_fvec), 32'h7F);
        check("sat_pass", 32'(s1_pass), 32'd0);
        $display("errw2 run: err_cnt=%0d fail_vec=%02h", s1_err, s1_fvec);

        repeat (30) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
